// File: rtl/camera_capture_ctrl_pkg.sv
// Shared types and helpers for the camera capture controller.
package camera_capture_ctrl_pkg;

   // Capture sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_SYNC    = 2'd2,
      ST_ACTIVE  = 2'd3
   } state_t;

   // Ceiling log2 used to size counters and pointers from parameters
   function automatic int cam_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/camera_capture_ctrl_fifo.sv
// Small synchronous FIFO holding packed words with their sideband bits.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module camera_capture_ctrl_fifo
   import camera_capture_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = cam_clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             do_pop;
   logic             do_push;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   // Head is forced to zero while empty so stale entries never appear on the bus
   assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

   // Storage write; contents need no reset because the head is gated by empty
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
   end

   // Pointer update; flush discards everything including a same-cycle push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

endmodule

// File: rtl/camera_capture_ctrl.sv
// Camera capture controller: frame sequencing, byte packing into words,
// line/frame bookkeeping and a valid/ready output FIFO.
module camera_capture_ctrl
   import camera_capture_ctrl_pkg::*;
#(
   parameter int BPW        = 4,
   parameter int H_BYTES    = 1280,
   parameter int V_LINES    = 480,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start_i,
   input  logic                              abort_i,
   input  logic                              continuous_i,
   input  logic                              vsync_i,
   input  logic                              href_i,
   input  logic [7:0]                        data_i,
   output logic [8*BPW-1:0]                  out_data_o,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic                              out_sof_o,
   output logic                              out_eol_o,
   output logic                              busy_o,
   output logic                              frame_done_o,
   output logic [15:0]                       frame_count_o,
   output logic [cam_clog2(V_LINES+1)-1:0]   line_count_o,
   output logic                              overflow_o,
   output logic                              line_err_o
);
   localparam int W   = 8 * BPW;
   localparam int IW  = cam_clog2(BPW);
   localparam int BCW = cam_clog2(H_BYTES + 2);
   localparam int LCW = cam_clog2(V_LINES + 1);

   state_t           state_q;
   logic             cont_q;
   logic [IW-1:0]    idx_q;
   logic [BCW-1:0]   byte_cnt_q;
   logic [W-1:0]     word_q;
   logic [W-1:0]     word_d;
   logic             href_prev_q;
   logic             sof_pend_q;
   logic             push_q;
   logic [W+1:0]     push_word_q;
   logic             frame_done_q;
   logic [15:0]      frame_count_q;
   logic [LCW-1:0]   line_count_q;
   logic             overflow_q;
   logic             line_err_q;

   logic             byte_en;
   logic             word_done;
   logic             href_fall;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [W+1:0]     fifo_head;

   assign byte_en   = (state_q == ST_ACTIVE) && href_i && !vsync_i;
   assign word_done = byte_en && (idx_q == IW'(BPW - 1));
   assign href_fall = (state_q == ST_ACTIVE) && href_prev_q && !href_i;
   assign fifo_pop  = out_valid_o && out_ready_i;

   // Lane merge: byte idx of a word goes to lane BPW-1-idx, so the first byte is the MSB
   for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      assign word_d[gi*8 +: 8] = (byte_en && (idx_q == IW'(BPW - 1 - gi))) ?
                                 data_i : word_q[gi*8 +: 8];
   end

   // Sequencer, packer, counters and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cont_q        <= 1'b0;
         idx_q         <= '0;
         byte_cnt_q    <= '0;
         word_q        <= '0;
         href_prev_q   <= 1'b0;
         sof_pend_q    <= 1'b0;
         push_q        <= 1'b0;
         push_word_q   <= '0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         line_count_q  <= '0;
         overflow_q    <= 1'b0;
         line_err_q    <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         push_q       <= 1'b0;
         href_prev_q  <= href_i;
         if (push_q && fifo_full && !fifo_pop && !abort_i) overflow_q <= 1'b1;

         if (abort_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            sof_pend_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i) begin
                     state_q       <= ST_WAIT_VS;
                     cont_q        <= continuous_i;
                     frame_count_q <= '0;
                     line_count_q  <= '0;
                     overflow_q    <= 1'b0;
                     line_err_q    <= 1'b0;
                  end
               end
               ST_WAIT_VS: begin
                  if (vsync_i) state_q <= ST_SYNC;
               end
               ST_SYNC: begin
                  if (!vsync_i) begin
                     state_q      <= ST_ACTIVE;
                     sof_pend_q   <= 1'b1;
                     idx_q        <= '0;
                     byte_cnt_q   <= '0;
                     line_count_q <= '0;
                  end
               end
               ST_ACTIVE: begin
                  if (vsync_i) begin
                     frame_done_q  <= 1'b1;
                     frame_count_q <= frame_count_q + 16'd1;
                     if (line_count_q != LCW'(V_LINES)) line_err_q <= 1'b1;
                     state_q       <= cont_q ? ST_SYNC : ST_IDLE;
                  end
                  if (byte_en) begin
                     word_q <= word_d;
                     if (byte_cnt_q != BCW'(H_BYTES + 1)) byte_cnt_q <= byte_cnt_q + BCW'(1);
                     if (word_done) begin
                        idx_q       <= '0;
                        push_q      <= 1'b1;
                        push_word_q <= {sof_pend_q, (byte_cnt_q == BCW'(H_BYTES - 1)), word_d};
                        sof_pend_q  <= 1'b0;
                     end else begin
                        idx_q <= idx_q + IW'(1);
                     end
                  end
                  if (href_fall) begin
                     if (line_count_q != '1) line_count_q <= line_count_q + LCW'(1);
                     if (byte_cnt_q != BCW'(H_BYTES)) line_err_q <= 1'b1;
                     idx_q      <= '0;
                     byte_cnt_q <= '0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   camera_capture_ctrl_fifo #(
      .WIDTH (W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (abort_i),
      .push_i  (push_q),
      .pop_i   (fifo_pop),
      .data_i  (push_word_q),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid_o   = !fifo_empty;
   assign out_data_o    = fifo_head[W-1:0];
   assign out_eol_o     = fifo_head[W];
   assign out_sof_o     = fifo_head[W+1];
   assign busy_o        = (state_q != ST_IDLE);
   assign frame_done_o  = frame_done_q;
   assign frame_count_o = frame_count_q;
   assign line_count_o  = line_count_q;
   assign overflow_o    = overflow_q;
   assign line_err_o    = line_err_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Bench for camera_capture_ctrl with small geometry: 4-byte words, 8-byte lines,
// 2-line frames and a 2-entry FIFO.
module tb_camera_capture_ctrl;
   localparam int BPW = 4;
   localparam int HB  = 8;
   localparam int VL  = 2;
   localparam int FD  = 2;

   typedef struct packed {
      logic        sof;
      logic        eol;
      logic [31:0] data;
   } word_t;

   typedef struct {
      int nl;
      int l0, l1, l2, l3;
      int exp_words;
      int exp_err;
      int exp_lc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0, continuous = 1'b0;
   logic        vsync = 1'b1, href = 1'b0, out_ready = 1'b1;
   logic [7:0]  data = 8'h00;
   logic [31:0] out_data;
   logic        out_valid, out_sof, out_eol, busy, frame_done, overflow, line_err;
   logic [15:0] frame_count;
   logic [1:0]  line_count;

   int    checks = 0;
   int    errors = 0;
   int    fd_cnt = 0;
   word_t got_q[$];
   word_t exp_q[$];
   int    line_len [4];
   bit    rand_data = 1'b1;
   bit    model_en  = 1'b1;
   logic [7:0] seq_b = 8'h00;
   vec_t  vt [7];

   camera_capture_ctrl #(.BPW(BPW), .H_BYTES(HB), .V_LINES(VL), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
      .continuous_i(continuous), .vsync_i(vsync), .href_i(href), .data_i(data),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_sof_o(out_sof), .out_eol_o(out_eol), .busy_o(busy),
      .frame_done_o(frame_done), .frame_count_o(frame_count),
      .line_count_o(line_count), .overflow_o(overflow), .line_err_o(line_err)
   );

   always #5 clk = ~clk;

   // Consumer side: record accepted words and frame_done pulses
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got_q.push_back({out_sof, out_eol, out_data});
      if (rst_n && frame_done) fd_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic check_words(input string tag);
      chk({tag, ".nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s.word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic push_exp(input logic s, input logic e, input logic [31:0] d);
      word_t w;
      w.sof = s; w.eol = e; w.data = d;
      exp_q.push_back(w);
   endtask

   // Drive one frame; the reference words are derived line by line from the bytes sent
   task automatic run_frame(input bit do_start, input bit cont, input int nl);
      logic [7:0] b [16];
      bit first;
      int len;
      first = 1'b1;
      if (do_start) begin
         start = 1'b1; continuous = cont; step();
         start = 1'b0;
      end
      vsync = 1'b1; repeat (3) step();
      vsync = 1'b0; repeat (2) step();
      for (int l = 0; l < nl; l++) begin
         len = line_len[l];
         for (int j = 0; j < len; j++) begin
            b[j] = rand_data ? 8'($urandom) : seq_b;
            seq_b = seq_b + 8'd1;
            href = 1'b1; data = b[j]; step();
         end
         href = 1'b0; data = 8'h00; repeat (2) step();
         if (model_en) begin
            for (int wi = 0; wi < len / BPW; wi++) begin
               push_exp(first, (len >= HB) && (wi == HB / BPW - 1),
                        {b[4*wi], b[4*wi+1], b[4*wi+2], b[4*wi+3]});
               first = 1'b0;
            end
         end
      end
      vsync = 1'b1; repeat (4) step();
   endtask

   task automatic drive_line(input logic [7:0] base, input int len);
      for (int j = 0; j < len; j++) begin
         href = 1'b1; data = base + 8'(j); step();
      end
      href = 1'b0; data = 8'h00;
   endtask

   initial begin
      int nsof;
      int exp_err;
      vt[0] = '{nl:2, l0:8,  l1:8, l2:0, l3:0, exp_words:4, exp_err:0, exp_lc:2};
      vt[1] = '{nl:2, l0:6,  l1:8, l2:0, l3:0, exp_words:3, exp_err:1, exp_lc:2};
      vt[2] = '{nl:1, l0:8,  l1:0, l2:0, l3:0, exp_words:2, exp_err:1, exp_lc:1};
      vt[3] = '{nl:2, l0:12, l1:8, l2:0, l3:0, exp_words:5, exp_err:1, exp_lc:2};
      vt[4] = '{nl:3, l0:8,  l1:8, l2:8, l3:0, exp_words:6, exp_err:1, exp_lc:3};
      vt[5] = '{nl:2, l0:9,  l1:3, l2:0, l3:0, exp_words:2, exp_err:1, exp_lc:2};
      vt[6] = '{nl:4, l0:8,  l1:8, l2:8, l3:8, exp_words:8, exp_err:1, exp_lc:3};

      // Reset state
      repeat (3) step();
      chk("reset.outputs", {out_data, out_valid, out_sof, out_eol, busy, frame_done,
                            frame_count, line_count, overflow, line_err}, 64'd0);
      rst_n = 1'b1; step();

      // Single shot, sequential bytes 00..0F
      rand_data = 1'b0; model_en = 1'b0; seq_b = 8'h00; fd_cnt = 0;
      line_len[0] = 8; line_len[1] = 8;
      run_frame(1'b1, 1'b0, 2);
      push_exp(1'b1, 1'b1 ^ 1'b1, 32'h00010203);
      push_exp(1'b0, 1'b1, 32'h04050607);
      push_exp(1'b0, 1'b0, 32'h08090A0B);
      push_exp(1'b0, 1'b1, 32'h0C0D0E0F);
      check_words("single");
      chk("single.frame_done_pulses", 64'(fd_cnt), 64'd1);
      chk("single.frame_count", 64'(frame_count), 64'd1);
      chk("single.busy", 64'(busy), 64'd0);
      chk("single.line_err", 64'(line_err), 64'd0);
      rand_data = 1'b1; model_en = 1'b1;

      // Asynchronous reset in the middle of a line with words waiting in the FIFO
      out_ready = 1'b0;
      start = 1'b1; continuous = 1'b0; step(); start = 1'b0;
      vsync = 1'b1; repeat (2) step(); vsync = 1'b0; repeat (2) step();
      drive_line(8'h40, 8); step();
      drive_line(8'h50, 3);
      href = 1'b1;
      chk("rst.pre_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst.mid_line_outputs", {out_data, out_valid, out_sof, out_eol, busy, frame_done,
                                      frame_count, line_count, overflow, line_err}, 64'd0);
      href = 1'b0; step();
      rst_n = 1'b1; out_ready = 1'b1;
      vsync = 1'b1; repeat (2) step(); vsync = 1'b0; repeat (2) step();
      drive_line(8'h60, 8); repeat (3) step();
      chk("rst.no_restart_busy", 64'(busy), 64'd0);
      chk("rst.no_restart_words", 64'(got_q.size()), 64'd0);
      got_q.delete();
      vsync = 1'b1; step();

      // Start while a frame is already running: wait for the next vsync pulse
      vsync = 1'b0; step();
      start = 1'b1; continuous = 1'b0; step(); start = 1'b0;
      drive_line(8'h70, 8); repeat (3) step();
      chk("midframe.busy", 64'(busy), 64'd1);
      chk("midframe.no_words", 64'(got_q.size()), 64'd0);
      fd_cnt = 0;
      line_len[0] = 8; line_len[1] = 8;
      run_frame(1'b0, 1'b0, 2);
      check_words("midframe");
      chk("midframe.frame_done_pulses", 64'(fd_cnt), 64'd1);

      // Continuous capture of three frames, then abort with a full FIFO
      fd_cnt = 0;
      run_frame(1'b1, 1'b1, 2);
      run_frame(1'b0, 1'b1, 2);
      run_frame(1'b0, 1'b1, 2);
      nsof = 0;
      foreach (got_q[i]) if (got_q[i].sof) nsof++;
      chk("cont.sof_count", 64'(nsof), 64'd3);
      check_words("cont");
      chk("cont.frame_done_pulses", 64'(fd_cnt), 64'd3);
      chk("cont.frame_count", 64'(frame_count), 64'd3);
      chk("cont.busy", 64'(busy), 64'd1);
      out_ready = 1'b0; vsync = 1'b0; step();
      drive_line(8'h80, 8); repeat (3) step();
      chk("abort.pre_valid", 64'(out_valid), 64'd1);
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1; vsync = 1'b1; repeat (3) step();
      chk("abort.flushed", 64'(got_q.size()), 64'd0);
      chk("abort.frame_done_pulses", 64'(fd_cnt), 64'd3);
      got_q.delete();

      // Backpressure with a 2-entry FIFO
      out_ready = 1'b0;
      start = 1'b1; continuous = 1'b0; step(); start = 1'b0;
      repeat (2) step(); vsync = 1'b0; repeat (2) step();
      for (int j = 0; j < 8; j++) begin
         href = 1'b1; data = 8'h20 + 8'(j); step();
         if (j == 3) chk("bp.latency_valid_low", 64'(out_valid), 64'd0);
         if (j == 4) chk("bp.latency_valid_high", 64'(out_valid), 64'd1);
      end
      href = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("bp.hold%0d", k), {out_valid, out_sof, out_eol, out_data},
             {3'b110, 32'h20212223});
      end
      chk("bp.no_overflow_yet", 64'(overflow), 64'd0);
      for (int j = 0; j < 8; j++) begin
         href = 1'b1; data = 8'h28 + 8'(j); step();
      end
      chk("bp.head_during_drop", 64'(out_data), 64'h20212223);
      out_ready = 1'b1; href = 1'b0; step();
      out_ready = 1'b0; step();
      chk("bp.overflow", 64'(overflow), 64'd1);
      chk("bp.head_after_swap", {out_sof, out_eol, out_data}, {2'b01, 32'h24252627});
      vsync = 1'b1; repeat (3) step();
      chk("bp.line_err", 64'(line_err), 64'd0);
      out_ready = 1'b1; repeat (4) step();
      push_exp(1'b1, 1'b0, 32'h20212223);
      push_exp(1'b0, 1'b1, 32'h24252627);
      push_exp(1'b0, 1'b1, 32'h2C2D2E2F);
      check_words("bp");

      // Table of line-length / line-count patterns
      for (int r = 0; r < 7; r++) begin
         line_len[0] = vt[r].l0; line_len[1] = vt[r].l1;
         line_len[2] = vt[r].l2; line_len[3] = vt[r].l3;
         fd_cnt = 0;
         run_frame(1'b1, 1'b0, vt[r].nl);
         chk($sformatf("vec%0d.nwords_table", r), 64'(got_q.size()), 64'(vt[r].exp_words));
         check_words($sformatf("vec%0d", r));
         chk($sformatf("vec%0d.line_err", r), 64'(line_err), 64'(vt[r].exp_err));
         chk($sformatf("vec%0d.line_count", r), 64'(line_count), 64'(vt[r].exp_lc));
         chk($sformatf("vec%0d.done_busy_fc", r), {fd_cnt[7:0], 7'd0, busy, frame_count},
             {8'd1, 8'd0, 16'd1});
      end

      // Randomized frames against the reference model
      for (int r = 0; r < 10; r++) begin
         int nl;
         nl = $urandom_range(1, 3);
         exp_err = (nl != VL);
         for (int l = 0; l < 4; l++) begin
            line_len[l] = ($urandom_range(0, 1) == 0) ? HB : $urandom_range(1, 12);
            if (l < nl && line_len[l] != HB) exp_err = 1;
         end
         fd_cnt = 0;
         run_frame(1'b1, 1'b0, nl);
         check_words($sformatf("rnd%0d", r));
         chk($sformatf("rnd%0d.line_err", r), 64'(line_err), 64'(exp_err));
         chk($sformatf("rnd%0d.line_count", r), 64'(line_count), 64'(nl));
         chk($sformatf("rnd%0d.frame_done_pulses", r), 64'(fd_cnt), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
